// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory-wait freezes,
// EX-stage operand forwarding and a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   async_reset,
  input  logic [5:0]             r1_D,
  input  logic [5:0]             r2_D,
  input  logic [5:0]             r1_E,
  input  logic [5:0]             r2_E,
  input  logic [5:0]             rd_E,
  input  logic [5:0]             rd_M,
  input  logic [5:0]             rd_W,
  input  logic                   write_scalar_reg_E,
  input  logic                   write_scalar_reg_M,
  input  logic                   write_scalar_reg_W,
  input  logic                   write_vector_reg_E,
  input  logic                   write_vector_reg_M,
  input  logic                   write_vector_reg_W,
  input  logic [1:0]             result_source_E,
  input  logic                   pc_source_E,
  input  logic                   memory_transaction_M,
  input  logic                   mem_ready,
  output logic                   enabler_F,
  output logic                   enabler_D,
  output logic                   enabler_E,
  output logic                   enabler_M,
  output logic                   enabler_W,
  output logic                   sync_reset_D,
  output logic                   sync_reset_E,
  output logic                   sync_reset_W,
  output logic [1:0]             forward_0_E,
  output logic [1:0]             forward_1_E,
  output logic                   mem_request,
  output logic                   mem_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   load_use, flush;

  // Bit 5 of the register id picks which write enable qualifies the match; scalar x0 never matches.
  function automatic logic reg_match(input logic [5:0] rs, input logic [5:0] rd,
                                     input logic ws, input logic wv);
    return (rs == rd) && (rd[5] ? wv : ws) && (rd != 6'b000000);
  endfunction

  assign load_use = (result_source_E == 2'b01) &&
                    (reg_match(r1_D, rd_E, write_scalar_reg_E, write_vector_reg_E) ||
                     reg_match(r2_D, rd_E, write_scalar_reg_E, write_vector_reg_E));
  assign flush    = pc_source_E;

  always_comb begin
    state_d      = state_q;
    enabler_F    = 1'b0;
    enabler_D    = 1'b0;
    enabler_E    = 1'b0;
    enabler_M    = 1'b0;
    enabler_W    = 1'b0;
    sync_reset_D = 1'b0;
    sync_reset_E = 1'b0;
    sync_reset_W = 1'b0;
    forward_0_E  = 2'b00;
    forward_1_E  = 2'b00;
    mem_request  = 1'b0;
    mem_busy     = 1'b0;

    if (async_reset) begin
      if (reg_match(r1_E, rd_M, write_scalar_reg_M, write_vector_reg_M))
        forward_0_E = 2'b10;
      else if (reg_match(r1_E, rd_W, write_scalar_reg_W, write_vector_reg_W))
        forward_0_E = 2'b01;
      if (reg_match(r2_E, rd_M, write_scalar_reg_M, write_vector_reg_M))
        forward_1_E = 2'b10;
      else if (reg_match(r2_E, rd_W, write_scalar_reg_W, write_vector_reg_W))
        forward_1_E = 2'b01;

      if ((state_q == RUN) && memory_transaction_M) begin
        mem_request  = 1'b1;
        sync_reset_W = 1'b1;
        state_d      = MEM_WAIT;
      end else if ((state_q == MEM_WAIT) && !mem_ready) begin
        sync_reset_W = 1'b1;
        mem_busy     = 1'b1;
      end else begin
        // Normal RUN cycle or the MEM_WAIT release cycle: deferred hazards resolve here.
        mem_busy  = (state_q == MEM_WAIT);
        state_d   = RUN;
        enabler_F = 1'b1;
        enabler_D = 1'b1;
        enabler_E = 1'b1;
        enabler_M = 1'b1;
        enabler_W = 1'b1;
        if (flush) begin
          sync_reset_D = 1'b1;
          sync_reset_E = 1'b1;
        end else if (load_use) begin
          enabler_F    = 1'b0;
          enabler_D    = 1'b0;
          sync_reset_E = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!enabler_F && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
